// File: rtl/resultado_bcd.sv
// Captures a finished 16-bit datapath result, converts it to 5 BCD digits with a
// sequential double-dabble, acknowledges the datapath and scans a 5-digit display.
module resultado_bcd #(
    parameter int DIV         = 4,
    parameter bit BLANK_ZEROS = 1
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [15:0] resultado,
    input  logic        led,
    output logic        pronto,
    output logic        valido,
    output logic [19:0] bcd,
    output logic [6:0]  seg,
    output logic [4:0]  an
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, ACK} state_t;

    state_t        state, state_nx;
    logic [15:0]   shreg;
    logic [19:0]   scratch;
    logic [3:0]    count;
    logic [19:0]   adj;
    logic [35:0]   shifted;
    logic [CW-1:0] refresh;
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic [4:0]    blank;

    // add-3 correction on every scratch digit, then one left shift of the pair
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        shifted = {adj, shreg} << 1;
    end

    always_comb begin
        state_nx = state;
        pronto   = 1'b0;
        case (state)
            IDLE: if (led) state_nx = CONV;
            CONV: if (count == 4'd15) state_nx = ACK;
            ACK: begin
                pronto = 1'b1;
                if (!led) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            bcd     <= '0;
            valido  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (led) begin
                    shreg   <= resultado;
                    scratch <= '0;
                    count   <= '0;
                end
                CONV: begin
                    {scratch, shreg} <= shifted;
                    count            <= count + 4'd1;
                    // bcd only moves here, so the display never sees partial work
                    if (count == 4'd15) begin
                        bcd    <= shifted[35:16];
                        valido <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            refresh <= '0;
            idx     <= '0;
        end else if (refresh == LAST) begin
            refresh <= '0;
            idx     <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    always_comb begin
        blank = '0;
        for (int k = 1; k < 5; k++)
            blank[k] = BLANK_ZEROS && ((bcd >> (4*k)) == 20'd0);
        case (idx)
            3'd0:    digit = bcd[3:0];
            3'd1:    digit = bcd[7:4];
            3'd2:    digit = bcd[11:8];
            3'd3:    digit = bcd[15:12];
            3'd4:    digit = bcd[19:16];
            default: digit = 4'hf;
        endcase
        an = ~(5'b00001 << idx);
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        if (idx <= 3'd4 && blank[idx])
            seg = 7'b1111111;
    end
endmodule

// File: tb/tb_resultado_bcd.sv
// Scoreboard bench for resultado_bcd: expected BCD values are queued when a
// result is offered and popped when pronto rises.
module tb_resultado_bcd;
    logic        ck = 1'b0;
    logic        rst;
    logic [15:0] resultado;
    logic        led;
    logic        pronto, valido;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic [4:0]  an;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [19:0] exp_q[$];
    bit          seen1234 = 1'b0;

    resultado_bcd #(.DIV(4), .BLANK_ZEROS(1)) dut (
        .ck(ck), .rst(rst), .resultado(resultado), .led(led),
        .pronto(pronto), .valido(valido), .bcd(bcd), .seg(seg), .an(an)
    );

    always #5 ck = ~ck;

    always @(posedge ck) if (bcd === 20'h01234) seen1234 <= 1'b1;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // offer v with led high for 'hold' edges; returns edges from E0 to pronto (-1 on timeout)
    task automatic run_conv(input logic [15:0] v, input int hold,
                            output int lat, output logic [19:0] got);
        exp_q.push_back(to_bcd(int'(v)));
        resultado = v;
        led = 1'b1;
        lat = -1;
        got = 'x;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == hold) led = 1'b0;
            if (pronto === 1'b1) begin
                lat = n - 1;
                got = bcd;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; led = 1'b0; resultado = '0;
        #2;
        n_cmp++; if (pronto !== 1'b0) begin n_bad++; $display("FAIL reset_pronto got=%b exp=0", pronto); end
        n_cmp++; if (valido !== 1'b0) begin n_bad++; $display("FAIL reset_valido got=%b exp=0", valido); end
        n_cmp++; if (bcd !== 20'h00000) begin n_bad++; $display("FAIL reset_bcd got=%h exp=00000", bcd); end
        n_cmp++; if (an !== 5'b11110) begin n_bad++; $display("FAIL reset_an got=%b exp=11110", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
        repeat (2) @(posedge ck);
        #1 rst = 1'b0;
    endtask

    task automatic test_nominal();
        int lat; logic [19:0] got, e;
        run_conv(16'd14, 5, lat, got);
        e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL nominal_bcd got=%h exp=%h", got, e); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL nominal_latency got=%0d exp=16", lat); end
        n_cmp++; if (valido !== 1'b1) begin n_bad++; $display("FAIL nominal_valido got=%b exp=1", valido); end
        tick();
        n_cmp++; if (pronto !== 1'b0) begin n_bad++; $display("FAIL nominal_pronto_clear got=%b exp=0", pronto); end
    endtask

    task automatic test_extremes();
        int lat; logic [19:0] got, e;
        logic [15:0] vals[3];
        vals[0] = 16'd65535; vals[1] = 16'd0; vals[2] = 16'd10000;
        foreach (vals[i]) begin
            run_conv(vals[i], 2, lat, got);
            e = exp_q.pop_front();
            n_cmp++; if (got !== e) begin n_bad++; $display("FAIL extreme_bcd[%0d] got=%h exp=%h", vals[i], got, e); end
            n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL extreme_latency[%0d] got=%0d exp=16", vals[i], lat); end
            tick();
        end
    endtask

    task automatic test_handshake();
        int lat; logic [19:0] got, e;
        bit ok;
        run_conv(16'd321, 40, lat, got);
        e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL hs_bcd got=%h exp=%h", got, e); end
        resultado = 16'd99;
        ok = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (pronto !== 1'b1 || bcd !== 20'h00321) ok = 1'b0;
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL hs_hold got=pronto %b bcd %h exp=pronto 1 bcd 00321", pronto, bcd); end
        led = 1'b0;
        tick();
        n_cmp++; if (pronto !== 1'b0) begin n_bad++; $display("FAIL hs_release got=%b exp=0", pronto); end
        run_conv(16'd99, 2, lat, got);
        e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL hs_second got=%h exp=%h", got, e); end
        tick();
    endtask

    task automatic test_async_reset();
        int lat; logic [19:0] got, e;
        run_conv(16'd7, 40, lat, got);
        e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL ar_bcd got=%h exp=%h", got, e); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (pronto !== 1'b0) begin n_bad++; $display("FAIL ar_pronto got=%b exp=0", pronto); end
        n_cmp++; if (valido !== 1'b0) begin n_bad++; $display("FAIL ar_valido got=%b exp=0", valido); end
        n_cmp++; if (bcd !== 20'h00000) begin n_bad++; $display("FAIL ar_bcd_clear got=%h exp=00000", bcd); end
        n_cmp++; if (an !== 5'b11110 || seg !== 7'b1000000)
            begin n_bad++; $display("FAIL ar_display got=%b/%b exp=11110/1000000", an, seg); end
        led = 1'b0;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_conv();
        int lat; logic [19:0] got, e;
        bit quiet;
        resultado = 16'd1234;
        led = 1'b1;
        tick();
        led = 1'b0;
        repeat (8) tick();
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (valido !== 1'b0) begin n_bad++; $display("FAIL rmc_valido got=%b exp=0", valido); end
        #2 rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pronto !== 1'b0 || valido !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (!quiet) begin n_bad++; $display("FAIL rmc_discard got=pronto %b valido %b exp=0 0", pronto, valido); end
        run_conv(16'd42, 2, lat, got);
        e = exp_q.pop_front();
        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rmc_bcd got=%h exp=%h", got, e); end
        n_cmp++; if (seen1234) begin n_bad++; $display("FAIL rmc_no1234 got=seen exp=never"); end
        tick();
    endtask

    task automatic test_display();
        logic [4:0] prev, ea;
        logic [6:0] es;
        bit found;
        found = 1'b0;
        prev = an;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev !== 5'b11110 && an === 5'b11110) found = 1'b1;
            prev = an;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL disp_sync got=timeout exp=an wrap to 11110"); end
        for (int d = 0; d < 10; d++) begin
            ea = ~(5'b00001 << (d % 5));
            case (d % 5)
                0:       es = 7'b0100100;
                1:       es = 7'b0011001;
                default: es = 7'b1111111;
            endcase
            for (int c = 0; c < 4; c++) begin
                n_cmp++; if (an !== ea || seg !== es) begin
                    n_bad++; $display("FAIL disp[%0d.%0d] got=%b/%b exp=%b/%b", d, c, an, seg, ea, es);
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_extremes();
        test_handshake();
        test_async_reset();
        test_reset_mid_conv();
        test_display();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
